pipe_delay: RTL and testbench



---
 rtl/pipe_delay_pkg.sv | 22 ++
 rtl/pipe_delay_stage.sv | 39 +++
 rtl/pipe_delay.sv | 97 +++++++++
 tb/tb_pipe_delay.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_delay_pkg.sv
// Shared types for pipe_delay: occupancy width helper and per-stage tag.
// PIPE_DELAY_PARITY_EN adds an even-parity bit to every stage tag.
package pipe_delay_pkg;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

`ifdef PIPE_DELAY_PARITY_EN
  localparam int PAR_BITS = 1;
  typedef struct packed {
    logic valid;
    logic parity;
  } stage_tag_t;
`else
  localparam int PAR_BITS = 0;
  typedef struct packed {
    logic valid;
  } stage_tag_t;
`endif

endpackage

// File: rtl/pipe_delay_stage.sv
// One delay-line register {valid, parity, data}; 1-cycle latency.
// Flush clears only valid; stall holds everything.
module pipe_delay_stage
  import pipe_delay_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             stall,
  input  stage_tag_t       d_tag,
  input  logic [WIDTH-1:0] d_dat,
  output stage_tag_t       q_tag,
  output logic [WIDTH-1:0] q_dat
);

  typedef struct packed {
    stage_tag_t       tag;
    logic [WIDTH-1:0] data;
  } stage_word_t;

  stage_word_t word_q;

  // Flush keeps data and parity so a flushed stage never looks corrupted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else if (flush) begin
      word_q.tag.valid <= 1'b0;
    end else if (!stall) begin
      word_q <= {d_tag, d_dat};
    end
  end

  assign q_tag = word_q.tag;
  assign q_dat = word_q.data;

endmodule

// File: rtl/pipe_delay.sv
// DEPTH-stage registered delay line with stall/flush and occupancy; latency DEPTH edges.
// Stall freezes all stages and refuses input; optional parity via PIPE_DELAY_PARITY_EN.
module pipe_delay
  import pipe_delay_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              x,
  input  logic                          in_valid,
  input  logic                          stall,
  input  logic                          flush,
  output logic [WIDTH-1:0]              y,
  output logic                          out_valid,
  output logic [occ_width(DEPTH)-1:0]   occupancy
`ifdef PIPE_DELAY_PARITY_EN
  ,
  output logic                          par_err
`endif
);

  localparam int OW = occ_width(DEPTH);

  stage_tag_t       tag_q [DEPTH];
  logic [WIDTH-1:0] dat_q [DEPTH];
  stage_tag_t       in_tag;
  logic [WIDTH-1:0] in_dat;
  logic [OW-1:0]    occ_q;

  // Bubbles enter as all-zero data so they carry parity 0 as well.
  always_comb begin
    in_dat       = in_valid ? x : '0;
    in_tag       = '0;
    in_tag.valid = in_valid;
`ifdef PIPE_DELAY_PARITY_EN
    in_tag.parity = ^in_dat;
`endif
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      pipe_delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .stall (stall),
        .d_tag (in_tag),
        .d_dat (in_dat),
        .q_tag (tag_q[i]),
        .q_dat (dat_q[i])
      );
    end else begin : g_body
      pipe_delay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .stall (stall),
        .d_tag (tag_q[i-1]),
        .d_dat (dat_q[i-1]),
        .q_tag (tag_q[i]),
        .q_dat (dat_q[i])
      );
    end
  end

  // Enter/leave accounting keeps the count equal to the number of valid stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (!stall) begin
      occ_q <= occ_q + OW'(in_valid) - OW'(tag_q[DEPTH-1].valid);
    end
  end

  assign occupancy = occ_q;
  assign out_valid = tag_q[DEPTH-1].valid;
  assign y         = out_valid ? dat_q[DEPTH-1] : '0;

`ifdef PIPE_DELAY_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (out_valid && ((^dat_q[DEPTH-1]) != tag_q[DEPTH-1].parity)) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_pipe_delay.sv
// Drives DEPTH=2/3/4 delay lines in parallel against an array-based reference model.
module tb_pipe_delay;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] x;
  logic       in_valid, stall, flush;

  logic [3:0] y2, y3, y4;
  logic       v2, v3, v4;
  logic [1:0] o2, o3;
  logic [2:0] o4;
`ifdef PIPE_DELAY_PARITY_EN
  logic       pe2, pe3, pe4;
`endif

  always #5 clk = ~clk;

  pipe_delay #(.WIDTH(4), .DEPTH(2)) dut2 (
`ifdef PIPE_DELAY_PARITY_EN
    .par_err(pe2),
`endif
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .stall(stall), .flush(flush),
    .y(y2), .out_valid(v2), .occupancy(o2));

  pipe_delay #(.WIDTH(4), .DEPTH(3)) dut3 (
`ifdef PIPE_DELAY_PARITY_EN
    .par_err(pe3),
`endif
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .stall(stall), .flush(flush),
    .y(y3), .out_valid(v3), .occupancy(o3));

  pipe_delay #(.WIDTH(4), .DEPTH(4)) dut4 (
`ifdef PIPE_DELAY_PARITY_EN
    .par_err(pe4),
`endif
    .clk(clk), .rst_n(rst_n), .x(x), .in_valid(in_valid), .stall(stall), .flush(flush),
    .y(y4), .out_valid(v4), .occupancy(o4));

  logic [31:0] oy [3];
  logic [31:0] ov [3];
  logic [31:0] oo [3];
  assign oy[0] = 32'(y2);
  assign oy[1] = 32'(y3);
  assign oy[2] = 32'(y4);
  assign ov[0] = 32'(v2);
  assign ov[1] = 32'(v3);
  assign ov[2] = 32'(v4);
  assign oo[0] = 32'(o2);
  assign oo[1] = 32'(o3);
  assign oo[2] = 32'(o4);

  int checks = 0;
  int errors = 0;

  // Reference: slot 0 is the newest word, slot depth-1 the oldest; -1 marks no word.
  int mq [3][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) mq[k][i] = -1;
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      int d;
      d = k + 2;
      if (flush) begin
        for (int i = 0; i < d; i++) mq[k][i] = -1;
      end else if (!stall) begin
        for (int i = d - 1; i > 0; i--) mq[k][i] = mq[k][i-1];
        mq[k][0] = in_valid ? int'(x) : -1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      int d, cnt, last;
      d    = k + 2;
      cnt  = 0;
      for (int i = 0; i < d; i++) if (mq[k][i] >= 0) cnt++;
      last = mq[k][d-1];
      chk($sformatf("%s_d%0d_vld", tag, d), ov[k], (last >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_d%0d_y", tag, d),   oy[k], (last >= 0) ? 32'(last) : 32'd0);
      chk($sformatf("%s_d%0d_occ", tag, d), oo[k], 32'(cnt));
    end
`ifdef PIPE_DELAY_PARITY_EN
    chk({tag, "_par_err"}, {29'd0, pe2, pe3, pe4}, 32'd0);
`endif
  endtask

  task automatic step(input string tag, input int xv, input bit iv, input bit st, input bit fl);
    x        = 4'(xv);
    in_valid = iv;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; x = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Latency on DEPTH=2: word sampled at edge e leaves after edge e+1.
    step("lat0", 5, 1, 0, 0);
    chk("lat0_v2", ov[0], 32'd0);
    chk("lat0_o2", oo[0], 32'd1);
    step("lat1", 0, 0, 0, 0);
    chk("lat1_y2", oy[0], 32'd5);
    chk("lat1_o2", oo[0], 32'd1);
    step("lat2", 0, 0, 0, 0);
    chk("lat2_v2", ov[0], 32'd0);
    chk("lat2_o2", oo[0], 32'd0);
    step("lat3", 0, 0, 0, 0);

    // Back-to-back streaming; DEPTH=3 full from the 3rd edge.
    for (int i = 1; i <= 5; i++) begin
      step("stream", i, 1, 0, 0);
      if (i >= 3) begin
        chk("stream_y3", oy[1], 32'(i - 2));
        chk("stream_o3", oo[1], 32'd3);
      end
    end
    step("stream_tail", 0, 0, 0, 0);
    chk("stream_tail_y3", oy[1], 32'd4);
    step("stream_tail", 0, 0, 0, 0);
    chk("stream_tail_y3", oy[1], 32'd5);
    step("clear", 0, 0, 0, 1);

    // Stall holds every stage and refuses the presented word.
    step("stl_ld", 7, 1, 0, 0);
    step("stl_ld", 9, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stl_hold", 15, 1, 1, 0);
      chk("stl_hold_y2", oy[0], 32'd7);
      chk("stl_hold_o2", oo[0], 32'd2);
    end
    step("stl_rel", 15, 1, 0, 0);
    chk("stl_rel_y2", oy[0], 32'd9);
    step("stl_drain", 0, 0, 0, 0);
    chk("stl_drain_y2", oy[0], 32'd15);
    step("stl_drain", 0, 0, 0, 0);
    chk("stl_empty_o2", oo[0], 32'd0);

    // Flush beats stall and drops the presented word.
    for (int i = 1; i <= 4; i++) step("fl_fill", i, 1, 0, 0);
    chk("fl_full_o4", oo[2], 32'd4);
    step("fl_hit", 8, 1, 1, 1);
    chk("fl_hit_v4", ov[2], 32'd0);
    chk("fl_hit_o4", oo[2], 32'd0);
    for (int i = 0; i < 4; i++) begin
      step("fl_after", 0, 0, 0, 0);
      chk("fl_after_v4", ov[2], 32'd0);
    end

    // Asynchronous reset between edges with DEPTH=3 full.
    for (int i = 1; i <= 3; i++) step("ar_fill", i + 10, 1, 0, 0);
    chk("ar_full_o3", oo[1], 32'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_v3", ov[1], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("ar_after", 0, 0, 0, 0);

    // Random stream with stalls and flushes.
    for (int n = 0; n < 400; n++) begin
      step("rand", int'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
